// File: rtl/of_tensor_pkg.sv
// of_tensor_pkg: shared definitions for the optical-flow confidence blocks.
// Holds the default tensor element width, the slot positions of the six
// structure-tensor elements inside the packed tensor bus, a slice helper
// and the fixed-point format of the reciprocal scale factor.
package of_tensor_pkg;

  localparam int TENSOR_WIDTH_DEF = 14;

  // Widest tensor element the slice helper supports.
  localparam int MAX_TW = 32;

  // Slot index of each element in the packed bus {xx,xy,xt,yy,yt,tt}.
  localparam int XX = 5;
  localparam int XY = 4;
  localparam int XT = 3;
  localparam int YY = 2;
  localparam int YT = 1;
  localparam int TT = 0;

  localparam int          RECIP_FRAC_DEF = 16;
  localparam logic [31:0] ONE_RECIP      = 32'd1 << RECIP_FRAC_DEF;

  // Returns slot idx of a tensor bus whose elements are w bits wide. The bus
  // is passed zero-extended to 6*MAX_TW bits; only the low w bits of the
  // result are meaningful and callers truncate to their element width.
  function automatic logic [MAX_TW-1:0] tensor_slice(input logic [6*MAX_TW-1:0] t,
                                                      input int w, input int idx);
    logic [6*MAX_TW-1:0] sh;
    sh = t >> (idx * w);
    return sh[MAX_TW-1:0];
  endfunction

endpackage

// File: rtl/round_shift_sat.sv
// round_shift_sat: combinational round-half-up right shift with saturation.
//   in_i  [IN_W]  unsigned fixed-point value
//   out_o [OUT_W] (in_i + 2^(SHIFT-1)) >> SHIFT, clipped to 2^(OUT_W-1)-1
//   sat_o         high when the clip was applied
// The result is non-negative and fits a signed OUT_W-bit field.
module round_shift_sat #(
  parameter int IN_W  = 63,
  parameter int SHIFT = 30,
  parameter int OUT_W = 14
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             sat_o
);

  localparam int QW = IN_W + 1 - SHIFT;
  localparam logic [QW-1:0] MAX_Q = QW'((64'd1 << (OUT_W - 1)) - 64'd1);

  logic [IN_W:0]  sum_s;
  logic [QW-1:0]  q_s;

  // One extra bit so adding the half-LSB can never wrap.
  assign sum_s = {1'b0, in_i} + ({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1));
  assign q_s   = QW'(sum_s >> SHIFT);

  // Clip to the largest positive signed OUT_W value.
  always_comb begin
    out_o = '0;
    sat_o = 1'b0;
    if (q_s > MAX_Q) begin
      out_o = OUT_W'(MAX_Q);
      sat_o = 1'b1;
    end else begin
      out_o = OUT_W'(q_s);
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/re_k_calc_pipe.sv
// re_k_calc_pipe: 7-stage residual-error variance and k calculator.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake (in_ready = global advance)
//   tensors, vx, vy, recip    sample: packed {xx,xy,xt,yy,yt,tt}, flow, scale
//   k_valid/k_ready           output handshake
//   k, k_sat, k_clamp         result and its qualifier flags
//   clamp_count               saturating count of delivered clamped results
// EV = tt*2^TW - (xt*vx + yt*vy)*2^(1+TW/2) + xx*vx^2 + yy*vy^2 + 2*xy*vx*vy,
// negative EV clamps to 0, then k = round(EV*recip / 2^(RECIP_FRAC+TW)).
module re_k_calc_pipe
  import of_tensor_pkg::*;
#(
  parameter int TENSOR_WIDTH = TENSOR_WIDTH_DEF,
  parameter int INTER_WIDTH  = TENSOR_WIDTH * 3 + 3,
  parameter int RECIP_W      = 18,
  parameter int RECIP_FRAC   = RECIP_FRAC_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [6*TENSOR_WIDTH-1:0]      tensors,
  input  logic signed [TENSOR_WIDTH-1:0] vx,
  input  logic signed [TENSOR_WIDTH-1:0] vy,
  input  logic [RECIP_W-1:0]             recip,
  output logic                           k_valid,
  input  logic                           k_ready,
  output logic signed [TENSOR_WIDTH-1:0] k,
  output logic                           k_sat,
  output logic                           k_clamp,
  output logic [CNT_W-1:0]               clamp_count
);

  localparam int TW = TENSOR_WIDTH;
  localparam int IW = INTER_WIDTH;
  localparam int H  = TW / 2;
  localparam int PW = IW + RECIP_W;

  function automatic logic signed [IW-1:0] sx(input logic signed [TW-1:0] a);
    return {{(IW - TW){a[TW-1]}}, a};
  endfunction

  logic signed [TW-1:0] xx_s, xy_s, xt_s, yy_s, yt_s, tt_s;
  logic                 advance_s;

  // Stage registers and their next-state values.
  logic signed [IW-1:0] xtvx_q, ytvy_q, vx2_q, vy2_q, vxvy_q, xy2_q, tt1_q, xx1_q, yy1_q;
  logic signed [IW-1:0] xtvx_d, ytvy_d, vx2_d, vy2_d, vxvy_d, xy2_d, tt1_d, xx1_d, yy1_d;
  logic signed [IW-1:0] t_tt_q, t_xt_q, t_yt_q, t_xx_q, t_yy_q, t_xy_q;
  logic signed [IW-1:0] t_tt_d, t_xt_d, t_yt_d, t_xx_d, t_yy_d, t_xy_d;
  logic signed [IW-1:0] sa_q, sb_q, ev_q, sa_d, sb_d, ev_d;
  logic [IW-1:0]        evc_q, evc_d;
  logic [PW-1:0]        p_q, p_d;
  logic [RECIP_W-1:0]   rc1_q, rc2_q, rc3_q, rc4_q, rc5_q;
  logic                 clamp5_q, clamp6_q, clamp5_d;

  logic [5:0]           vld_q;
  logic                 k_valid_q, k_sat_q, k_clamp_q;
  logic [TW-1:0]        k_q, rss_k_s;
  logic                 rss_sat_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign xx_s = TW'(tensor_slice((6*MAX_TW)'(tensors), TW, XX));
  assign xy_s = TW'(tensor_slice((6*MAX_TW)'(tensors), TW, XY));
  assign xt_s = TW'(tensor_slice((6*MAX_TW)'(tensors), TW, XT));
  assign yy_s = TW'(tensor_slice((6*MAX_TW)'(tensors), TW, YY));
  assign yt_s = TW'(tensor_slice((6*MAX_TW)'(tensors), TW, YT));
  assign tt_s = TW'(tensor_slice((6*MAX_TW)'(tensors), TW, TT));

  // The whole pipeline moves only when the output slot is free or draining.
  assign advance_s = !k_valid_q || k_ready;
  assign in_ready  = advance_s;

  // Datapath next-state for stages S1..S6.
  always_comb begin
    // S1: first-level products, buffer the rest
    xtvx_d = sx(xt_s) * sx(vx);
    ytvy_d = sx(yt_s) * sx(vy);
    vx2_d  = sx(vx) * sx(vx);
    vy2_d  = sx(vy) * sx(vy);
    vxvy_d = sx(vx) * sx(vy);
    xy2_d  = sx(xy_s) <<< 1;
    tt1_d  = sx(tt_s);
    xx1_d  = sx(xx_s);
    yy1_d  = sx(yy_s);
    // S2: scaling and second-level products
    t_tt_d = tt1_q <<< TW;
    t_xt_d = xtvx_q <<< (H + 1);
    t_yt_d = ytvy_q <<< (H + 1);
    t_xx_d = xx1_q * vx2_q;
    t_yy_d = yy1_q * vy2_q;
    t_xy_d = xy2_q * vxvy_q;
    // S3/S4: partial sums then EV
    sa_d   = t_tt_q - t_xt_q - t_yt_q;
    sb_d   = t_xx_q + t_yy_q + t_xy_q;
    ev_d   = sa_q + sb_q;
    // S5: clamp negative variance
    if (ev_q[IW-1]) begin
      evc_d    = '0;
      clamp5_d = 1'b1;
    end else begin
      evc_d    = ev_q;
      clamp5_d = 1'b0;
    end
    // S6: unsigned scale
    p_d = PW'(evc_q) * PW'(rc5_q);
  end

  round_shift_sat #(
    .IN_W  (PW),
    .SHIFT (RECIP_FRAC + TW),
    .OUT_W (TW)
  ) u_rss (
    .in_i  (p_q),
    .out_o (rss_k_s),
    .sat_o (rss_sat_s)
  );

  // Datapath stage registers; hold on stall, contents qualified by vld_q.
  always_ff @(posedge clk) begin
    if (advance_s) begin
      xtvx_q <= xtvx_d; ytvy_q <= ytvy_d; vx2_q <= vx2_d; vy2_q <= vy2_d;
      vxvy_q <= vxvy_d; xy2_q <= xy2_d; tt1_q <= tt1_d; xx1_q <= xx1_d; yy1_q <= yy1_d;
      t_tt_q <= t_tt_d; t_xt_q <= t_xt_d; t_yt_q <= t_yt_d;
      t_xx_q <= t_xx_d; t_yy_q <= t_yy_d; t_xy_q <= t_xy_d;
      sa_q <= sa_d; sb_q <= sb_d; ev_q <= ev_d;
      evc_q <= evc_d; clamp5_q <= clamp5_d;
      p_q <= p_d; clamp6_q <= clamp5_q;
      rc1_q <= recip; rc2_q <= rc1_q; rc3_q <= rc2_q; rc4_q <= rc3_q; rc5_q <= rc4_q;
    end
  end

  // Clamp counter next-state: count delivered clamped results, stick at max.
  always_comb begin
    cnt_d = cnt_q;
    if (k_valid_q && k_ready && k_clamp_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control, output stage and counter, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 6'b000000;
      k_valid_q <= 1'b0;
      k_q       <= '0;
      k_sat_q   <= 1'b0;
      k_clamp_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance_s) begin
        vld_q     <= {vld_q[4:0], in_valid};
        k_valid_q <= vld_q[5];
        k_q       <= rss_k_s;
        k_sat_q   <= rss_sat_s;
        k_clamp_q <= clamp6_q;
      end
    end
  end

  assign k_valid     = k_valid_q;
  assign k           = k_q;
  assign k_sat       = k_sat_q;
  assign k_clamp     = k_clamp_q;
  assign clamp_count = cnt_q;

endmodule

// File: tb/tb_re_k_calc_pipe.sv
module tb_re_k_calc_pipe;
  import of_tensor_pkg::*;

  localparam int TW = 14;
  localparam int RW = 18;
  localparam int CW = 16;

  typedef longint unsigned u64_t;
  typedef struct packed {
    logic [TW-1:0] k;
    logic          sat;
    logic          clamp;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, k_valid, k_ready, k_sat, k_clamp;
  logic [6*TW-1:0]      tensors;
  logic signed [TW-1:0] vx, vy, k;
  logic [RW-1:0]        recip;
  logic [CW-1:0]        clamp_count;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  re_k_calc_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .tensors(tensors), .vx(vx), .vy(vy), .recip(recip),
    .k_valid(k_valid), .k_ready(k_ready), .k(k), .k_sat(k_sat),
    .k_clamp(k_clamp), .clamp_count(clamp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6*TW-1:0] pack6(int xx, int xy, int xt, int yy, int yt, int tt);
    logic [6*TW-1:0] t;
    t = '0;
    t[XX*TW +: TW] = TW'(xx);
    t[XY*TW +: TW] = TW'(xy);
    t[XT*TW +: TW] = TW'(xt);
    t[YY*TW +: TW] = TW'(yy);
    t[YT*TW +: TW] = TW'(yt);
    t[TT*TW +: TW] = TW'(tt);
    return t;
  endfunction

  function automatic longint slot(logic [6*TW-1:0] t, int idx);
    logic signed [TW-1:0] s;
    s = t[idx*TW +: TW];
    return longint'(s);
  endfunction

  // Reference: exact integer arithmetic on the variance formula, then
  // rounded division by 2^30 and clipping to 8191.
  function automatic exp_t ref_model(logic [6*TW-1:0] t, logic signed [TW-1:0] fx,
                                     logic signed [TW-1:0] fy, logic [RW-1:0] rc);
    exp_t   e;
    longint ev, x, y;
    u64_t   p, q;
    x  = longint'(fx);
    y  = longint'(fy);
    ev = slot(t, TT) * 16384 - slot(t, XT) * x * 256 - slot(t, YT) * y * 256
       + slot(t, XX) * x * x + slot(t, YY) * y * y + 2 * slot(t, XY) * x * y;
    e.clamp = (ev < 0);
    if (ev < 0) ev = 0;
    p = u64_t'(ev) * u64_t'(rc);
    q = (p + 64'd536870912) / 64'd1073741824;
    if (q > 64'd8191) begin
      e.k = TW'(8191);
      e.sat = 1'b1;
    end else begin
      e.k = TW'(q);
      e.sat = 1'b0;
    end
    return e;
  endfunction

  // Advance one cycle: record what the coming edge accepts, end at negedge.
  task automatic tick();
    #1;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (in_valid && in_ready) begin
      exp_q.push_back(ref_model(tensors, vx, vy, recip));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; k_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    k_ready = 1'b0;
    #1;
    total += 6;
    if (k_valid !== 1'b0) begin bad++; $display("FAIL rst_k_valid: got %b want 0", k_valid); end
    if (k !== '0) begin bad++; $display("FAIL rst_k: got %0d want 0", k); end
    if (k_sat !== 1'b0) begin bad++; $display("FAIL rst_k_sat: got %b want 0", k_sat); end
    if (k_clamp !== 1'b0) begin bad++; $display("FAIL rst_k_clamp: got %b want 0", k_clamp); end
    if (clamp_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", clamp_count); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    k_ready = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int d_tt[5] = '{1, 100, 0, 8191, 500};
    int d_xt[5] = '{0, 0, 100, 0, 0};
    int d_vx[5] = '{0, 0, 100, 0, 0};
    int d_rc[5] = '{65536, 2341, 65536, 262143, 0};
    int d_k[5]  = '{1, 4, 0, 8191, 0};
    int d_s[5]  = '{0, 0, 0, 1, 0};
    int d_c[5]  = '{0, 0, 1, 0, 0};
    exp_t e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      tensors = pack6(0, 0, d_xt[i], 0, 0, d_tt[i]);
      vx = TW'(d_vx[i]); vy = '0; recip = RW'(d_rc[i]);
      in_valid = 1'b1; k_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!k_valid && lat < 20) begin tick(); lat++; end
      total += 4;
      if (lat != 7) begin bad++; $display("FAIL dir%0d_latency: got %0d want 7", i, lat); end
      if (k !== TW'(d_k[i])) begin bad++; $display("FAIL dir%0d_k: got %0d want %0d", i, k, d_k[i]); end
      if (k_sat !== 1'(d_s[i])) begin bad++; $display("FAIL dir%0d_sat: got %b want %0d", i, k_sat, d_s[i]); end
      if (k_clamp !== 1'(d_c[i])) begin bad++; $display("FAIL dir%0d_clamp: got %b want %0d", i, k_clamp, d_c[i]); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.clamp) exp_cnt++;
      end
      tick();
      total++;
      if (k_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_drop: got k_valid %b want 0", i, k_valid); end
    end
    total++;
    if (clamp_count !== CW'(exp_cnt)) begin bad++; $display("FAIL dir_count: got %0d want %0d", clamp_count, exp_cnt); end
  endtask

  task automatic test_random();
    exp_t e;
    logic stall_prev = 1'b0;
    logic [TW-1:0] hk = '0;
    logic hs = 1'b0, hc = 1'b0;
    int cyc;
    for (cyc = 0; cyc < 700; cyc++) begin
      if (cyc >= 600 && exp_q.size() == 0) break;
      if (cyc < 600) begin
        in_valid = ($urandom_range(0, 3) != 0);
        k_ready  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) begin
          tensors = (6*TW)'({$urandom(), $urandom(), $urandom()});
          vx = TW'($urandom()); vy = TW'($urandom());
        end else begin
          tensors = pack6(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                          int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                          int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 8191)));
          vx = TW'(int'($urandom_range(0, 40)) - 20); vy = TW'(int'($urandom_range(0, 40)) - 20);
        end
        case ($urandom_range(0, 7))
          0: recip = '0;
          1: recip = RW'(ONE_RECIP);
          2, 3: recip = RW'($urandom());
          default: recip = RW'($urandom_range(0, 4095));
        endcase
      end else begin
        in_valid = 1'b0; k_ready = 1'b1;
      end
      #1;
      if (stall_prev) begin
        total++;
        if (k !== hk || k_sat !== hs || k_clamp !== hc) begin
          bad++; $display("FAIL rnd_stable: got %0d/%b/%b want %0d/%b/%b", k, k_sat, k_clamp, hk, hs, hc);
        end
      end
      if (k_valid && k_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_extra: got unexpected k=%0d want none", k);
        end else begin
          e = exp_q.pop_front();
          if (e.clamp) exp_cnt++;
          if (k !== e.k || k_sat !== e.sat || k_clamp !== e.clamp) begin
            bad++; $display("FAIL rnd_k: got %0d/%b/%b want %0d/%b/%b", k, k_sat, k_clamp, e.k, e.sat, e.clamp);
          end
        end
      end
      stall_prev = k_valid && !k_ready;
      hk = k; hs = k_sat; hc = k_clamp;
      tick();
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d pending want 0", exp_q.size()); end
    if (clamp_count !== CW'(exp_cnt)) begin bad++; $display("FAIL rnd_count: got %0d want %0d", clamp_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n_sent = 0, n_out = 0;
    logic saw_full = 1'b0, stall_prev = 1'b0;
    logic [TW-1:0] hk = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (n_out == 10) break;
      k_ready  = !(cyc >= 3 && cyc <= 12);
      in_valid = (n_sent < 10);
      tensors  = pack6(0, 0, 0, 0, 0, n_sent + 1);
      vx = '0; vy = '0; recip = RW'(ONE_RECIP);
      #1;
      if (!in_ready) begin
        saw_full = 1'b1;
        total++;
        if (exp_q.size() != 7) begin bad++; $display("FAIL b2b_full: got %0d in flight want 7", exp_q.size()); end
      end
      if (stall_prev) begin
        total++;
        if (k !== hk) begin bad++; $display("FAIL b2b_stable: got %0d want %0d", k, hk); end
      end
      if (k_valid && k_ready) begin
        total++;
        if (k !== TW'(n_out + 1)) begin bad++; $display("FAIL b2b_order: got %0d want %0d", k, n_out + 1); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_out++;
      end
      if (in_valid && in_ready) n_sent++;
      stall_prev = k_valid && !k_ready;
      hk = k;
      tick();
    end
    in_valid = 1'b0;
    k_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (k_valid !== 1'b0) begin bad++; $display("FAIL b2b_dup: got extra k=%0d want none", k); end
      tick();
    end
    total += 2;
    if (n_out != 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", n_out); end
    if (!saw_full) begin bad++; $display("FAIL b2b_backpressure: got in_ready never low want low"); end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int lat;
    k_ready = 1'b1;
    recip = RW'(ONE_RECIP); vx = '0; vy = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      tensors = pack6(0, 0, 0, 0, 0, i + 2);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 2;
    if (k_valid !== 1'b0) begin bad++; $display("FAIL mrst_k_valid: got %b want 0", k_valid); end
    if (clamp_count !== '0) begin bad++; $display("FAIL mrst_count: got %0d want 0", clamp_count); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (k_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale: got k=%0d want none", k); end
      tick();
    end
    tensors = pack6(0, 0, 0, 0, 0, 5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!k_valid && lat < 20) begin tick(); lat++; end
    total += 3;
    if (lat != 7) begin bad++; $display("FAIL mrst_latency: got %0d want 7", lat); end
    if (k !== TW'(5)) begin bad++; $display("FAIL mrst_k: got %0d want 5", k); end
    if (k_sat !== 1'b0 || k_clamp !== 1'b0) begin
      bad++; $display("FAIL mrst_flags: got %b/%b want 0/0", k_sat, k_clamp);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; k_ready = 1'b1;
    tensors = '0; vx = '0; vy = '0; recip = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/re_k_calc_pipe.md
Name: re_k_calc_pipe

Overview:
Parametrised successor to the fixed-ratio k calculator in the optical-flow confidence path. The block computes the residual error variance of a structure tensor against a flow vector (vx, vy). It then scales that variance by a per-sample programmable reciprocal factor that replaces the hardwired P/(RATIO·(N−P)) divide, and rounds and saturates the result to k. It adds a valid/ready handshake with full backpressure, clamping of negative variance, saturation flags and a clamp event counter.

Parameters:
TENSOR_WIDTH, 14, signed width of each tensor element, vx, vy and k
INTER_WIDTH, TENSOR_WIDTH*3+3, internal signed accumulation width
RECIP_W, 18, unsigned width of recip
RECIP_FRAC, 16, fractional bits of recip (65536 = 1.0)
CNT_W, 16, width of clamp_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept sample this cycle
tensors  in  6*TENSOR_WIDTH  {xx,xy,xt,yy,yt,tt}, xx in MSBs, tt in LSBs, each signed
vx  in  TENSOR_WIDTH  signed flow x
vy  in  TENSOR_WIDTH  signed flow y
recip  in  RECIP_W  unsigned scale factor, sampled with the data
k_valid  out  1  result valid
k_ready  in  1  downstream accepts result
k  out  TENSOR_WIDTH  signed result, always ≥ 0
k_sat  out  1  k was saturated (qualifies k)
k_clamp  out  1  variance was negative and clamped to 0 (qualifies k)
clamp_count  out  CNT_W  number of clamp events since reset, saturating

Behaviour:
- Reset: one clock (clk) only; rst is synchronous and active-high. While rst is high on a clock edge, all stage valids, k_valid, k, k_sat, k_clamp and clamp_count become 0. Reset mid-operation discards in-flight samples; there is no partial output.
- Handshake:
  - advance = !k_valid | k_ready, global stall; in_ready = advance.
  - A sample is accepted when in_valid & in_ready.
  - When advance is 0, all stages hold.
  - k, k_sat and k_clamp stay stable while k_valid & !k_ready.
- Latency: 7 cycles from accept to k_valid with no stall; throughput 1/cycle; order preserved.
- Let H = TENSOR_WIDTH/2. The variance is EV = tt·2^TW − xt·vx·2^(1+H) − yt·vy·2^(1+H) + xx·vx² + yy·vy² + 2·xy·vx·vy. All terms are signed at INTER_WIDTH.
- Pipeline stages:
  - S1: xt·vx, yt·vy, vx², vy², vx·vy, 2·xy; tt, xx, yy and recip are buffered.
  - S2: the ×2 and second products are formed.
  - S3: partial sums.
  - S4: EV.
  - S5: clamp; if EV<0, EVc=0 and clamp=1.
  - S6: P = EVc·recip, unsigned, width INTER_WIDTH+RECIP_W.
  - S7: q = (P + 2^(RECIP_FRAC+TW−1)) >> (RECIP_FRAC+TW), round half up. If q > 2^(TW−1)−1, then k = 2^(TW−1)−1 and k_sat=1; otherwise k = q.
- recip = 0 gives k = 0 with no sat. A clamped sample gives k = 0 and k_sat = 0.
- clamp_count increments on each k_valid & k_ready handshake with k_clamp=1 and holds at 2^CNT_W−1.
- Simultaneous accept and output in the same cycle is legal. A full pipeline with k_ready held low fills all 7 stages, then in_ready=0.

Decomposition:
- Shared package of_tensor_pkg holds:
  - the TENSOR_WIDTH default;
  - tensor slot indices: XX=5, XY=4, XT=3, YY=2, YT=1, TT=0;
  - a tensor slice function;
  - the RECIP_FRAC default and the ONE_RECIP constant (1<<RECIP_FRAC).
- Sub-module round_shift_sat (S7: add half-LSB, shift, unsigned saturate to signed TW, sat flag), parametrised by IN_W, SHIFT and OUT_W. It is reusable by other confidence blocks.

Test Plan:
- tt=1, others 0, vx=vy=0, recip=65536 → k=1 exactly 7 cycles after accept; k_sat=0, k_clamp=0.
- tt=100, others 0, recip=2341 → EV=1638400, k=4.
- xt=100, vx=100, others 0 → EV=−2560000, k=0, k_clamp=1; after handshake clamp_count=1.
- tt=8191, recip=262143 → k=8191, k_sat=1.
- Back-to-back stream of 10 samples (tt=1..10, recip=65536) with k_ready low for cycles 3–12:
  - in_ready drops once 7 samples are in flight;
  - outputs are k=1..10 in order with none lost or duplicated;
  - k is stable while stalled.
- Assert rst for 1 cycle while 4 samples are in flight → next cycle k_valid=0 and clamp_count=0; no stale outputs appear afterwards; a new sample gives its correct result 7 cycles after accept.
